// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and button channel indices.
// Imported by the menu controller and by the display/audio blocks.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_START  = 3'd0,
        ST_MENU   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int BTN_PREV    = 0;
    localparam int BTN_NEXT    = 1;
    localparam int BTN_CONFIRM = 2;

endpackage

// File: rtl/btn_conditioner.sv
// One button channel: 2-FF synchroniser, stable-level debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;
    logic             deb_dly_q;
    logic             pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            // Any return to the accepted level restarts the stability window
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                deb_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            deb_dly_q <= deb_q;
            pulse_q   <= deb_q & ~deb_dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/menu_state_ctrl.sv
// Song menu controller: conditions the raw buttons and runs the
// START/MENU/PLAY/PAUSE/FINISH state machine with song selection.
module menu_state_ctrl
    import game_pkg::*;
#(
    parameter int  NUM_BTN      = 3,
    parameter int  NUM_SONGS    = 3,
    parameter int  DEBOUNCE_CYC = 4,
    localparam int SEL_W        = $clog2(NUM_SONGS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               finish,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [STATE_W-1:0] state,
    output logic [SEL_W-1:0]   song_sel,
    output logic [SEL_W-1:0]   song_confirm
);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SONGS);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_cond (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn[i]),
            .pulse_o(btn_pulse[i])
        );
    end

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] confirm_q;
    logic [SEL_W-1:0] sel_inc_d;
    logic [SEL_W-1:0] sel_dec_d;
    logic             p_prev;
    logic             p_next;
    logic             p_conf;

    assign p_prev = btn_pulse[BTN_PREV];
    assign p_next = btn_pulse[BTN_NEXT];
    assign p_conf = btn_pulse[BTN_CONFIRM];

    // Selection wraps within 1..NUM_SONGS; 0 (nothing chosen) enters either end
    always_comb begin
        sel_inc_d = (sel_q == SEL_MAX) ? SEL_ONE : sel_q + SEL_ONE;
        sel_dec_d = (sel_q <= SEL_ONE) ? SEL_MAX : sel_q - SEL_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_START;
            sel_q     <= '0;
            confirm_q <= '0;
        end else begin
            confirm_q <= '0;
            unique case (state_q)
                ST_START: begin
                    if (|btn_pulse) state_q <= ST_MENU;
                end
                ST_MENU: begin
                    if (p_conf) begin
                        if (sel_q != '0) begin
                            state_q   <= ST_PLAY;
                            confirm_q <= sel_q;
                        end
                    end else if (p_next && !p_prev) begin
                        sel_q <= sel_inc_d;
                    end else if (p_prev && !p_next) begin
                        sel_q <= sel_dec_d;
                    end
                end
                ST_PLAY: begin
                    if (finish)      state_q <= ST_FINISH;
                    else if (p_conf) state_q <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (p_conf)      state_q <= ST_PLAY;
                    else if (p_prev) state_q <= ST_MENU;
                end
                ST_FINISH: begin
                    if (p_conf) state_q <= ST_MENU;
                end
                default: state_q <= ST_START;
            endcase
        end
    end

    assign state        = state_q;
    assign song_sel     = sel_q;
    assign song_confirm = confirm_q;

endmodule
